rr_mux_arbiter: RTL and testbench

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

---
 rtl/rr_mux_arbiter_pkg.sv | 25 ++
 rtl/rr_mux_arbiter_if.sv | 31 +++
 rtl/rr_mux_arbiter_mux.sv | 26 ++
 rtl/rr_mux_arbiter.sv | 101 ++++++++++
 tb/tb_rr_mux_arbiter.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants and the rotating-priority search used by the round-robin arbiter.
// Latency: n/a (declarations and a pure combinational helper).
// Backpressure: n/a.
package rr_mux_arbiter_pkg;

  localparam int N_REQ  = 4;
  localparam int SEL_W  = 2;
  localparam int HOLD_W = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // First set bit at or above ptr, wrapping 3 -> 0. Descending scan so the
  // smallest rotational offset is the last (winning) assignment.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [SEL_W-1:0] ptr);
    logic [SEL_W-1:0] idx;
    rr_pick = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Request/grant/data bundle between requesters (master) and the arbiter (slave).
// Latency: n/a (wiring only).
// Backpressure: none; requesters hold req until they see their grant and release.
interface rr_mux_arbiter_if
  import rr_mux_arbiter_pkg::*;
#(
  parameter int WIDTH = 4
) ();

  logic [N_REQ-1:0] req;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic [N_REQ-1:0] gnt;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic [WIDTH-1:0] out;
  logic             out_valid;

  modport master (
    output req, in0, in1, in2, in3,
    input  gnt, sel, busy, out, out_valid
  );

  modport slave (
    input  req, in0, in1, in2, in3,
    output gnt, sel, busy, out, out_valid
  );

endinterface

// File: rtl/rr_mux_arbiter_mux.sv
// Parameterised 4:1 data multiplexer (MuxParam).
// Latency: combinational.
// Backpressure: none.
module MuxParam #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  input  logic [WIDTH-1:0] d2_i,
  input  logic [WIDTH-1:0] d3_i,
  input  logic [1:0]       s_i,
  output logic [WIDTH-1:0] y_o
);

  // Route the selected lane straight through.
  always_comb begin
    y_o = d0_i;
    case (s_i)
      2'd0:    y_o = d0_i;
      2'd1:    y_o = d1_i;
      2'd2:    y_o = d2_i;
      default: y_o = d3_i;
    endcase
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Four-way round-robin arbiter with bounded hold time and a registered data mux.
// Latency: grant one cycle after request seen in IDLE; out/out_valid one cycle after gnt.
// Backpressure: owner keeps grant while req holds, up to MAX_HOLD cycles; one IDLE cycle between owners.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  rr_mux_arbiter_if.slave bus
);

  logic [0:0]       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] pick;
  logic [WIDTH-1:0] mux_y;

  MuxParam #(.WIDTH(WIDTH)) u_mux (
    .d0_i (bus.in0),
    .d1_i (bus.in1),
    .d2_i (bus.in2),
    .d3_i (bus.in3),
    .s_i  (sel_q),
    .y_o  (mux_y)
  );

  assign pick = rr_pick(bus.req, ptr_q);

  // Arbitration FSM: pick a winner from IDLE, hold it in GRANT until release or hold limit.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    out_d       = out_q;
    out_valid_d = 1'b0;

    if (state_q == ST_IDLE) begin
      gnt_d = '0;
      if (|bus.req) begin
        state_d = ST_GRANT;
        gnt_d   = N_REQ'(1) << pick;
        sel_d   = pick;
        ptr_d   = pick + SEL_W'(1);
        hold_d  = HOLD_W'(1);
      end
    end else begin
      // Data path follows the owner one cycle behind the grant.
      out_d       = mux_y;
      out_valid_d = 1'b1;
      if (bus.req[sel_q] && (hold_q < HOLD_W'(MAX_HOLD))) begin
        hold_d = hold_q + HOLD_W'(1);
      end else begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        hold_d  = '0;
      end
    end

    busy_d = (state_d == ST_GRANT);
  end

  // State and output registers; reset drops any grant in flight immediately.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      sel_q       <= '0;
      ptr_q       <= '0;
      hold_q      <= '0;
      busy_q      <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      busy_q      <= busy_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = busy_q;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed vectors with hand-derived per-cycle expectations,
// scoreboard queue drained by a monitor on the falling edge, plus a protocol checker.
// Two instances: MAX_HOLD = 8 (default) and MAX_HOLD = 2 (hold-limit rotation).
module tb_rr_mux_arbiter;

  typedef struct packed {
    logic       tgt;   // 0: MAX_HOLD=8 instance, 1: MAX_HOLD=2 instance
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       ov;
    logic [3:0] out;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  logic started;
  exp_t sb[$];

  rr_mux_arbiter_if #(.WIDTH(4)) if8 ();
  rr_mux_arbiter_if #(.WIDTH(4)) if2 ();

  rr_mux_arbiter #(.WIDTH(4), .MAX_HOLD(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  rr_mux_arbiter #(.WIDTH(4), .MAX_HOLD(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req_v);
    n_checks++;
    if (act == req_v) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, req_v);
  endtask

  // Drive one cycle of stimulus; the expectation describes the state after the edge.
  task automatic step(input logic rst, input logic [3:0] r, input logic tgt,
                      input logic [3:0] g, input logic [1:0] s,
                      input logic ov, input logic [3:0] o);
    exp_t e;
    rst_n   = rst;
    if8.req = r;
    if2.req = r;
    @(posedge clk);
    e.tgt = tgt; e.gnt = g; e.sel = s; e.ov = ov; e.out = o;
    sb.push_back(e);
    started = 1'b1;
    #1;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [3:0] ag, ao;
      logic [1:0] as;
      logic       ab, aov;
      e = sb.pop_front();
      if (e.tgt) begin
        ag = if2.gnt; as = if2.sel; ab = if2.busy; aov = if2.out_valid; ao = if2.out;
      end else begin
        ag = if8.gnt; as = if8.sel; ab = if8.busy; aov = if8.out_valid; ao = if8.out;
      end
      check(e.tgt ? "h2_gnt" : "h8_gnt", int'(ag), int'(e.gnt));
      check(e.tgt ? "h2_sel" : "h8_sel", int'(as), int'(e.sel));
      check(e.tgt ? "h2_busy" : "h8_busy", int'(ab), int'(|e.gnt));
      check(e.tgt ? "h2_out_valid" : "h8_out_valid", int'(aov), int'(e.ov));
      check(e.tgt ? "h2_out" : "h8_out", int'(ao), int'(e.out));
    end
  end

  // Protocol checker on both instances every cycle.
  logic [3:0] prev8, prev2;
  always @(negedge clk) begin
    if (started) begin
      check("h8_onehot0", int'($onehot0(if8.gnt)), 1);
      check("h2_onehot0", int'($onehot0(if2.gnt)), 1);
      check("h8_busy_gnt", int'(if8.busy), int'(|if8.gnt));
      check("h2_busy_gnt", int'(if2.busy), int'(|if2.gnt));
      check("h8_no_overlap", int'((prev8 != 0) && (if8.gnt != 0) && (if8.gnt != prev8)), 0);
      check("h2_no_overlap", int'((prev2 != 0) && (if2.gnt != 0) && (if2.gnt != prev2)), 0);
    end
    prev8 = if8.gnt;
    prev2 = if2.gnt;
  end

  initial begin
    #100000;
    $display("FAIL timeout n_checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] g;
    logic [1:0] w, prev;
    n_checks = 0;
    n_pass   = 0;
    started  = 1'b0;
    prev8    = '0;
    prev2    = '0;
    rst_n    = 1'b0;
    if8.req = '0; if2.req = '0;
    if8.in0 = 4'd0; if8.in1 = 4'd1; if8.in2 = 4'd2; if8.in3 = 4'd3;
    if2.in0 = 4'd0; if2.in1 = 4'd1; if2.in2 = 4'd2; if2.in3 = 4'd3;

    // Reset state (MAX_HOLD=2 instance)
    step(0, 4'b0000, 1, 4'b0000, 2'd0, 0, 4'd0);
    step(0, 4'b0000, 1, 4'b0000, 2'd0, 0, 4'd0);

    // All requesting, MAX_HOLD=2: two grant cycles, one idle, rotate 0,1,2,3
    prev = 2'd0;
    for (int k = 0; k < 4; k++) begin
      w = 2'(k);
      g = 4'b0001 << k;
      step(1, 4'b1111, 1, g,       w, 0, {2'b00, prev});
      step(1, 4'b1111, 1, g,       w, 1, {2'b00, w});
      step(1, 4'b1111, 1, 4'b0000, w, 1, {2'b00, w});
      prev = w;
    end
    // Wraps back to requester 0
    step(1, 4'b1111, 1, 4'b0001, 2'd0, 0, 4'd3);
    step(1, 4'b1111, 1, 4'b0001, 2'd0, 1, 4'd0);
    // Only requester 0 left: hold expires, re-granted after one idle cycle
    step(1, 4'b0001, 1, 4'b0000, 2'd0, 1, 4'd0);
    step(1, 4'b0001, 1, 4'b0001, 2'd0, 0, 4'd0);
    step(1, 4'b0001, 1, 4'b0001, 2'd0, 1, 4'd0);

    // Scenario 1 on MAX_HOLD=8: single requester 2
    step(0, 4'b0000, 0, 4'b0000, 2'd0, 0, 4'd0);
    step(0, 4'b0000, 0, 4'b0000, 2'd0, 0, 4'd0);
    step(1, 4'b0100, 0, 4'b0100, 2'd2, 0, 4'd0);
    step(1, 4'b0100, 0, 4'b0100, 2'd2, 1, 4'd2);
    step(1, 4'b0000, 0, 4'b0000, 2'd2, 1, 4'd2);
    step(1, 4'b0000, 0, 4'b0000, 2'd2, 0, 4'd2);

    // Scenario 3: owner 1 releases after 3 grant cycles, requester 3 waiting
    step(0, 4'b0000, 0, 4'b0000, 2'd0, 0, 4'd0);
    step(1, 4'b1010, 0, 4'b0010, 2'd1, 0, 4'd0);
    step(1, 4'b1010, 0, 4'b0010, 2'd1, 1, 4'd1);
    step(1, 4'b1010, 0, 4'b0010, 2'd1, 1, 4'd1);
    step(1, 4'b1000, 0, 4'b0000, 2'd1, 1, 4'd1);
    step(1, 4'b1000, 0, 4'b1000, 2'd3, 0, 4'd1);
    step(1, 4'b1000, 0, 4'b1000, 2'd3, 1, 4'd3);
    step(1, 4'b0000, 0, 4'b0000, 2'd3, 1, 4'd3);

    // Scenario 4: req[0] raised during requester 2's grant has no effect until release
    step(1, 4'b0100, 0, 4'b0100, 2'd2, 0, 4'd3);
    step(1, 4'b0101, 0, 4'b0100, 2'd2, 1, 4'd2);
    step(1, 4'b0101, 0, 4'b0100, 2'd2, 1, 4'd2);
    step(1, 4'b0001, 0, 4'b0000, 2'd2, 1, 4'd2);
    step(1, 4'b0001, 0, 4'b0001, 2'd0, 0, 4'd2);
    step(1, 4'b0001, 0, 4'b0001, 2'd0, 1, 4'd0);

    // Scenario 5: reset mid-grant of requester 3, then arbitration restarts at 0
    step(1, 4'b1000, 0, 4'b0000, 2'd0, 1, 4'd0);
    step(1, 4'b1000, 0, 4'b1000, 2'd3, 0, 4'd0);
    step(1, 4'b1000, 0, 4'b1000, 2'd3, 1, 4'd3);
    step(0, 4'b1010, 0, 4'b0000, 2'd0, 0, 4'd0);
    step(1, 4'b1010, 0, 4'b0010, 2'd1, 0, 4'd0);
    step(1, 4'b0000, 0, 4'b0000, 2'd1, 1, 4'd1);
    step(1, 4'b0000, 0, 4'b0000, 2'd1, 0, 4'd1);

    @(negedge clk);
    #1;
    check("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
